// File: rtl/line_buffer_3row_pkg.sv
// Shared definitions for the Conv2d line-buffer input stage: pixel width, FSM encoding and
// counter width helpers.
package line_buffer_3row_pkg;

    localparam int unsigned DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StFlush  = 2'd2,
        StDone   = 2'd3
    } state_e;

    function automatic int unsigned col_width(input int unsigned img_w);
        return (img_w > 1) ? $clog2(img_w) : 1;
    endfunction

    // One extra code point so the row counter can hold IMG_H during the flush row.
    function automatic int unsigned row_width(input int unsigned img_h);
        return $clog2(img_h + 1);
    endfunction

endpackage

// File: rtl/line_buffer_3row_if.sv
// Pixel stream in, window column out; master is the upstream/control side, slave the buffer.
interface line_buffer_3row_if
    import line_buffer_3row_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = line_buffer_3row_pkg::DATA_WIDTH,
    parameter int unsigned COL_W      = 5,
    parameter int unsigned ROW_W      = 6
);
    logic                  start;
    logic [DATA_WIDTH-1:0] in_pixel;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_row_n;
    logic [DATA_WIDTH-1:0] out_row_n_1;
    logic [DATA_WIDTH-1:0] out_row_n_2;
    logic                  out_wr_window;
    logic                  out_shift_window;
    logic [COL_W-1:0]      out_col;
    logic [ROW_W-1:0]      out_row;
    logic                  busy;
    logic                  frame_done;

    modport master (
        output start, in_pixel, in_valid,
        input  in_ready, out_row_n, out_row_n_1, out_row_n_2, out_wr_window,
               out_shift_window, out_col, out_row, busy, frame_done
    );

    modport slave (
        input  start, in_pixel, in_valid,
        output in_ready, out_row_n, out_row_n_1, out_row_n_2, out_wr_window,
               out_shift_window, out_col, out_row, busy, frame_done
    );
endinterface

// File: rtl/line_buffer_3row_line_mem.sv
// One image-row line memory: single write port, asynchronous read at the same address, so a
// read in the write cycle returns the old contents.
module line_buffer_3row_line_mem
    import line_buffer_3row_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = line_buffer_3row_pkg::DATA_WIDTH,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/line_buffer_3row.sv
// Raster pixel stream to vertical 3-pixel window columns, with top zero padding gated by the
// row counter and an optional zero flush row below the image.
module line_buffer_3row
    import line_buffer_3row_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = line_buffer_3row_pkg::DATA_WIDTH,
    parameter int unsigned IMG_W      = 32,
    parameter int unsigned IMG_H      = 32,
    parameter int unsigned PAD_BOTTOM = 1
) (
    input logic               clk,
    input logic               rst,
    line_buffer_3row_if.slave bus
);

    localparam int unsigned COL_W = col_width(IMG_W);
    localparam int unsigned ROW_W = row_width(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] ROW_FLUSH = ROW_W'(IMG_H);

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    logic                  xfer, flush, mem_we;
    logic [DATA_WIDTH-1:0] mem1_wdata, mem1_rdata, mem0_rdata;

    logic [DATA_WIDTH-1:0] out_n_q, out_n1_q, out_n2_q;
    logic [COL_W-1:0]      out_col_q;
    logic [ROW_W-1:0]      out_row_q;
    logic                  strobe_q, done_q;

    assign xfer       = (state_q == StStream) && bus.in_valid;
    assign flush      = (state_q == StFlush);
    assign mem_we     = xfer || flush;
    assign mem1_wdata = xfer ? bus.in_pixel : '0;

    // mem1 holds row r-1 and feeds mem0 (row r-2) at the same column.
    line_buffer_3row_line_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (IMG_W),
        .ADDR_W    (COL_W)
    ) u_mem1 (
        .clk  (clk),
        .we   (mem_we),
        .addr (col_q),
        .wdata(mem1_wdata),
        .rdata(mem1_rdata)
    );

    line_buffer_3row_line_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (IMG_W),
        .ADDR_W    (COL_W)
    ) u_mem0 (
        .clk  (clk),
        .we   (mem_we),
        .addr (col_q),
        .wdata(mem1_rdata),
        .rdata(mem0_rdata)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StStream;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            StStream: begin
                if (xfer) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            state_d = (PAD_BOTTOM != 0) ? StFlush : StDone;
                            row_d   = (PAD_BOTTOM != 0) ? ROW_FLUSH : '0;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            StFlush: begin
                if (col_q == COL_LAST) begin
                    state_d = StDone;
                    col_d   = '0;
                    row_d   = '0;
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Stale line-memory contents never reach the outputs for rows 0 and 1 of a new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_n_q   <= '0;
            out_n1_q  <= '0;
            out_n2_q  <= '0;
            out_col_q <= '0;
            out_row_q <= '0;
            strobe_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            strobe_q <= mem_we;
            done_q   <= (state_q == StDone);
            if (mem_we) begin
                out_n_q   <= mem1_wdata;
                out_n1_q  <= (row_q != '0) ? mem1_rdata : '0;
                out_n2_q  <= (row_q > ROW_W'(1)) ? mem0_rdata : '0;
                out_col_q <= col_q;
                out_row_q <= row_q;
            end
        end
    end

    assign bus.in_ready         = (state_q == StStream);
    assign bus.busy             = (state_q != StIdle);
    assign bus.out_row_n        = out_n_q;
    assign bus.out_row_n_1      = out_n1_q;
    assign bus.out_row_n_2      = out_n2_q;
    assign bus.out_wr_window    = strobe_q;
    assign bus.out_shift_window = strobe_q;
    assign bus.out_col          = out_col_q;
    assign bus.out_row          = out_row_q;
    assign bus.frame_done       = done_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Bench for line_buffer_3row: a 4x3 image through a padded and an unpadded instance, checked
// every cycle against a frame-level model plus literal window-column expectations.
module tb_line_buffer_3row;

    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int CW = 2;
    localparam int RW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic          start0, start1;
    logic [DW-1:0] pix;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    line_buffer_3row_if #(.DATA_WIDTH(DW), .COL_W(CW), .ROW_W(RW)) bus0 ();
    line_buffer_3row_if #(.DATA_WIDTH(DW), .COL_W(CW), .ROW_W(RW)) bus1 ();

    assign bus0.start    = start0;
    assign bus0.in_pixel = pix;
    assign bus0.in_valid = valid;
    assign bus1.start    = start1;
    assign bus1.in_pixel = pix;
    assign bus1.in_valid = valid;

    line_buffer_3row #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .PAD_BOTTOM(1)) u_dut0 (
        .clk(clk),
        .rst(rst),
        .bus(bus0.slave)
    );

    line_buffer_3row #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .PAD_BOTTOM(0)) u_dut1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1.slave)
    );

    logic          a_rdy[2], a_busy[2], a_fd[2], a_wr[2], a_sh[2];
    logic [DW-1:0] a_n[2], a_n1[2], a_n2[2];
    logic [CW-1:0] a_col[2];
    logic [RW-1:0] a_row[2];

    assign a_rdy[0] = bus0.in_ready;        assign a_rdy[1] = bus1.in_ready;
    assign a_busy[0] = bus0.busy;           assign a_busy[1] = bus1.busy;
    assign a_fd[0] = bus0.frame_done;       assign a_fd[1] = bus1.frame_done;
    assign a_wr[0] = bus0.out_wr_window;    assign a_wr[1] = bus1.out_wr_window;
    assign a_sh[0] = bus0.out_shift_window; assign a_sh[1] = bus1.out_shift_window;
    assign a_n[0] = bus0.out_row_n;         assign a_n[1] = bus1.out_row_n;
    assign a_n1[0] = bus0.out_row_n_1;      assign a_n1[1] = bus1.out_row_n_1;
    assign a_n2[0] = bus0.out_row_n_2;      assign a_n2[1] = bus1.out_row_n_2;
    assign a_col[0] = bus0.out_col;         assign a_col[1] = bus1.out_col;
    assign a_row[0] = bus0.out_row;         assign a_row[1] = bus1.out_row;

    // Frame-level model: the accepted image plus progress counts per instance.
    bit active[2];
    bit chk_en[2];
    int acc[2], fl[2];
    int img[2][N];
    int e_n[2], e_n1[2], e_n2[2], e_col[2], e_row[2];
    bit e_stb[2], e_fd[2];
    int fd_count[2];
    int log0[$];
    int log1[$];

    function automatic int col3(input int n, input int n1, input int n2);
        return n * 1000000 + n1 * 1000 + n2;
    endfunction

    task automatic chk(input string nm, input int p, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d at %0t: got %0d expected %0d", nm, p, $time, act, exp);
        end
    endtask

    task automatic pin(input string nm, input int p, input int idx, input int n, input int n1,
                       input int n2);
        int got;
        got = -1;
        if (p == 0) begin
            if (idx < log0.size()) got = log0[idx];
        end else begin
            if (idx < log1.size()) got = log1[idx];
        end
        n_checks++;
        if (got != col3(n, n1, n2)) begin
            n_fail++;
            $display("FAIL %s dut%0d column %0d: got %0d expected %0d", nm, p, idx, got,
                     col3(n, n1, n2));
        end
    endtask

    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            int r, c;
            bit st, pad;
            if (chk_en[p]) begin
                chk("in_ready", p, 32'(a_rdy[p]), 32'(active[p] && acc[p] < N));
                chk("busy", p, 32'(a_busy[p]), 32'(active[p]));
                chk("frame_done", p, 32'(a_fd[p]), 32'(e_fd[p]));
                chk("wr_window", p, 32'(a_wr[p]), 32'(e_stb[p]));
                chk("shift_window", p, 32'(a_sh[p]), 32'(e_stb[p]));
                chk("row_n", p, 32'(a_n[p]), e_n[p]);
                chk("row_n_1", p, 32'(a_n1[p]), e_n1[p]);
                chk("row_n_2", p, 32'(a_n2[p]), e_n2[p]);
                chk("out_col", p, 32'(a_col[p]), e_col[p]);
                chk("out_row", p, 32'(a_row[p]), e_row[p]);
            end
            if (a_wr[p] === 1'b1) begin
                if (p == 0) log0.push_back(col3(int'(a_n[p]), int'(a_n1[p]), int'(a_n2[p])));
                else        log1.push_back(col3(int'(a_n[p]), int'(a_n1[p]), int'(a_n2[p])));
            end
            if (a_fd[p] === 1'b1) fd_count[p]++;

            // Predict the effect of the coming rising edge.
            st  = (p == 0) ? start0 : start1;
            pad = (p == 0);
            if (rst) begin
                chk_en[p] = 1'b1;
                active[p] = 1'b0;
                acc[p]    = 0;
                fl[p]     = 0;
                e_stb[p]  = 1'b0;
                e_fd[p]   = 1'b0;
                e_n[p]    = 0; e_n1[p] = 0; e_n2[p] = 0; e_col[p] = 0; e_row[p] = 0;
            end else begin
                e_stb[p] = 1'b0;
                e_fd[p]  = 1'b0;
                if (!active[p]) begin
                    if (st) begin
                        active[p] = 1'b1;
                        acc[p]    = 0;
                        fl[p]     = 0;
                    end
                end else if (acc[p] < N) begin
                    if (valid) begin
                        r = acc[p] / W;
                        c = acc[p] % W;
                        img[p][acc[p]] = int'(pix);
                        e_n[p]   = int'(pix);
                        e_n1[p]  = (r >= 1) ? img[p][acc[p] - W] : 0;
                        e_n2[p]  = (r >= 2) ? img[p][acc[p] - 2 * W] : 0;
                        e_col[p] = c;
                        e_row[p] = r;
                        e_stb[p] = 1'b1;
                        acc[p]++;
                    end
                end else if (pad && fl[p] < W) begin
                    e_n[p]   = 0;
                    e_n1[p]  = img[p][(H - 1) * W + fl[p]];
                    e_n2[p]  = img[p][(H - 2) * W + fl[p]];
                    e_col[p] = fl[p];
                    e_row[p] = H;
                    e_stb[p] = 1'b1;
                    fl[p]++;
                end else begin
                    active[p] = 1'b0;
                    e_fd[p]   = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        log0.delete();
        log1.delete();
        start0 = 1'b1;
        start1 = 1'b1;
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic stream_pixel(input int v);
        int k;
        pix   = DW'(v);
        valid = 1'b1;
        k     = 0;
        while (bus0.in_ready !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        if (k >= 20) chk("in_ready_timeout", 0, 32'(bus0.in_ready), 32'd1);
        tick();
    endtask

    task automatic stream_range(input int first, input int last);
        for (int v = first; v <= last; v++) stream_pixel(v);
        valid = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (bus0.frame_done === 1'b1) seen = 1'b1;
        end
        if (!seen) chk("frame_done_timeout", 0, 32'd0, 32'd1);
    endtask

    initial begin
        int fd0_before, fd1_before;
        rst = 1'b1; valid = 1'b0; start0 = 1'b0; start1 = 1'b0; pix = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_busy", 0, 32'(bus0.busy), 32'd0);
        chk("reset_in_ready", 0, 32'(bus0.in_ready), 32'd0);
        chk("reset_strobe", 1, 32'(bus1.out_wr_window), 32'd0);
        tick();

        // Continuous stream of 1..12.
        start_frame();
        for (int v = 1; v <= N; v++) stream_pixel(v);
        valid = 1'b0;
        chk("ready_after_last_pad0", 1, 32'(bus1.in_ready), 32'd0);
        chk("ready_in_flush", 0, 32'(bus0.in_ready), 32'd0);
        wait_done();
        pin("row0", 0, 0, 1, 0, 0);
        pin("row0", 0, 1, 2, 0, 0);
        pin("row0", 0, 2, 3, 0, 0);
        pin("row0", 0, 3, 4, 0, 0);
        pin("row2", 0, 8, 9, 5, 1);
        pin("flush0", 0, 12, 0, 9, 5);
        pin("flush3", 0, 15, 0, 12, 8);
        pin("last_pad0", 1, 11, 12, 8, 4);
        chk("strobes_pad1", 0, 32'(log0.size()), 32'd16);
        chk("strobes_pad0", 1, 32'(log1.size()), 32'd12);
        tick();

        // Gaps in row 1, with start pulses during STREAM and FLUSH.
        start_frame();
        stream_range(1, 5);
        start0 = 1'b1; start1 = 1'b1;
        tick();
        start0 = 1'b0; start1 = 1'b0;
        tick();
        stream_range(6, 12);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_done();
        pin("gap_pixel6", 0, 5, 6, 2, 0);
        pin("gap_pixel6", 1, 5, 6, 2, 0);
        chk("gap_strobes", 0, 32'(log0.size()), 32'd16);
        tick();

        // Abort mid-frame, start+rst together, then a clean frame.
        fd0_before = fd_count[0];
        fd1_before = fd_count[1];
        start_frame();
        stream_range(1, 7);
        rst = 1'b1;
        tick();
        rst = 1'b1; start0 = 1'b1; start1 = 1'b1;
        tick();
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
        tick();
        chk("idle_after_rst_start", 0, 32'(bus0.busy), 32'd0);
        chk("idle_after_rst_start", 1, 32'(bus1.busy), 32'd0);
        start_frame();
        stream_range(101, 112);
        wait_done();
        pin("after_abort_row0", 0, 0, 101, 0, 0);
        pin("after_abort_row0", 0, 3, 104, 0, 0);
        pin("after_abort_row1", 0, 4, 105, 101, 0);
        pin("after_abort_row2", 0, 8, 109, 105, 101);
        pin("after_abort_row1", 1, 4, 105, 101, 0);

        // Back-to-back frame started while frame_done is high.
        start_frame();
        stream_range(1, 12);
        wait_done();
        tick();
        pin("b2b_row0", 0, 0, 1, 0, 0);
        pin("b2b_row0", 0, 2, 3, 0, 0);
        pin("b2b_row1", 0, 4, 5, 1, 0);
        pin("b2b_row1", 1, 4, 5, 1, 0);
        chk("frame_done_count", 0, 32'(fd_count[0] - fd0_before), 32'd2);
        chk("frame_done_count", 1, 32'(fd_count[1] - fd1_before), 32'd2);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/line_buffer_3row.md
Name: line_buffer_3row

Overview:
- Streaming raster-order pixel input stage that sits directly upstream of the 3x3 window register in the Conv2d datapath.
- Keeps the two previous image rows in circular line memories.
- Each accepted pixel is presented as one vertical 3-pixel column (rows n, n-1, n-2) with a combined write+shift strobe for the window register.
- Applies zero padding for rows above the image and, optionally, emits one flush row of zeros below the image for "same" convolution.

Parameters:
DATA_WIDTH, 16, pixel width in bits
IMG_W, 32, image width in pixels (>=2)
IMG_H, 32, image height in rows (>=2)
PAD_BOTTOM, 1, 1 = emit one extra zero row after the last image row; 0 = no flush
COL_W, $clog2(IMG_W), column counter width (derived; not overridden)
ROW_W, $clog2(IMG_H+1), row counter width (derived; not overridden)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE
in_pixel  in  DATA_WIDTH  incoming pixel, raster order
in_valid  in  1  in_pixel valid
in_ready  out  1  block accepts a pixel; a transfer happens when in_valid && in_ready
out_row_n  out  DATA_WIDTH  current-row pixel (bottom row of the window column)
out_row_n_1  out  DATA_WIDTH  pixel from the previous row, same column
out_row_n_2  out  DATA_WIDTH  pixel from two rows back, same column
out_wr_window  out  1  column valid; drives Wr_window downstream
out_shift_window  out  1  drives Shift_window downstream; always equal to out_wr_window
out_col  out  COL_W  column index of the presented column
out_row  out  ROW_W  row index of the presented column (IMG_H during flush)
busy  out  1  high in STREAM, FLUSH and DONE
frame_done  out  1  one-cycle pulse after the last column of the frame has been presented

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, col/row counters=0, all outputs 0 (in_ready=0). Line memories are not cleared; padding is gated by the row counter.
- FSM states:
  - IDLE: in_ready=0. start -> STREAM with counters=0.
  - STREAM: in_ready=1. Each transfer advances col; when col wraps at IMG_W-1, col=0 and row+1. The transfer at (IMG_H-1, IMG_W-1) goes to FLUSH if PAD_BOTTOM=1, otherwise to DONE.
  - FLUSH: in_ready=0. One column per cycle for col 0..IMG_W-1 with row=IMG_H, then -> DONE.
  - DONE: frame_done=1 for exactly one cycle, then -> IDLE.
- Line memories: mem1 holds row r-1, mem0 holds row r-2, each IMG_W deep.
  - On each transfer at column c: mem0[c] <= mem1[c] and mem1[c] <= in_pixel.
  - Both memories are read combinationally at c in the same cycle (read-before-write).
- Output for a transfer at (r, c), registered, latency exactly 1 cycle:
  - out_row_n = in_pixel.
  - out_row_n_1 = (r>=1) ? mem1[c] : 0.
  - out_row_n_2 = (r>=2) ? mem0[c] : 0.
  - out_wr_window = out_shift_window = 1; out_col = c; out_row = r.
- Flush column c: out_row_n = 0, out_row_n_1 = mem1[c], out_row_n_2 = mem0[c]. The memories shift the same way with 0 written into mem1.
- Cycles with no transfer or flush: strobes = 0. Data and index outputs hold their last values.
- STREAM with in_valid=0 stalls: counters hold, no strobe.
- start outside IDLE is ignored. start and rst in the same cycle: rst wins.
- rst mid-frame: aborts on the next edge. No frame_done, strobes drop, and the next frame starts cleanly from row 0 because padding is row-gated.
- Timing: the last STREAM strobe occurs 1 cycle after the last transfer. With PAD_BOTTOM=1, the IMG_W flush strobes follow back-to-back. frame_done is high on the cycle after the final strobe.
- No arithmetic beyond the counters. Counters compare against IMG_W-1 and IMG_H-1 and never exceed those limits, except out_row=IMG_H during flush.

Decomposition:
- Shared conv2d package holds DATA_WIDTH, the FSM state encoding (IDLE=0, STREAM=1, FLUSH=2, DONE=3) and the clog2-based width helpers.
- One natural sub-module: line_mem, a single-port-write, async-read IMG_W x DATA_WIDTH register array with read-before-write. It is instantiated twice (mem0, mem1).
- The FSM, counters and output registers stay in the top module.

Test Plan:
1. IMG_W=4, IMG_H=3, PAD_BOTTOM=1; rst, start, stream pixels 1..12 with in_valid=1 continuously.
   - Row 0 columns: (n, n-1, n-2) = (1,0,0) (2,0,0) (3,0,0) (4,0,0).
   - Row 2 column 0 = (9,5,1).
   - Flush column 0 = (0,9,5).
   - 16 strobes in total, frame_done 1 cycle after the last strobe.
2. Same frame with PAD_BOTTOM=0: exactly 12 strobes. frame_done on the cycle after the strobe for pixel 12. in_ready=0 from the cycle after pixel 12 is accepted.
3. Toggle in_valid 1,0,0,1 during row 1: strobes occur only 1 cycle after transfers. out_col/out_row hold during gaps. Pixel 6 maps to (6,2,0).
4. Assert rst after pixel 7 is accepted, then start a new frame with pixels 101..112.
   - No frame_done from the aborted frame.
   - Row 0 of the new frame shows n-1 = n-2 = 0, not stale values.
5. Pulse start during STREAM and during FLUSH: ignored, no counter change. start and rst together in IDLE: block stays in IDLE.
6. Back-to-back frames (start the cycle after frame_done): the second frame's row-1 column 0 = (105,101,0), with no leakage from the first frame.
